// File: rtl/apb_bridge_q.sv
// apb_bridge_q
//   Queued APB4 requester bridge for the DFE filter array register bus.
//   Commands enter through a valid/ready port into a FIFO_DEPTH-entry queue.
//   Each popped command is latched and decoded, then driven through the APB
//   SETUP/ACCESS sequence. The result comes back on a valid/ready response port.
//
// Handshake rule for both cmd_* and rsp_* ports: a transfer happens on a
// rising PCLK edge where valid && ready are both 1. A source holds its
// payload stable while valid=1 and ready=0.
//
// Ports
//   PCLK, PRESET      clock, synchronous active-high reset
//   cmd_*             command input (valid/ready, write, addr, wdata, strb)
//   rsp_*             response output (valid/ready, rdata, err)
//   busy              queue non-empty, command latched, or transfer in flight
//   PSELx..PSLVERR    APB4 requester interface, one PSEL bit per completer
//   dbg_state         FSM state (0=IDLE, 1=SETUP, 2=ACCESS)
module apb_bridge_q #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,   // 8, 16 or 32
    parameter int COMP       = 4,    // number of completers, >= 2
    parameter int SEL_LSB    = 8,
    parameter int FIFO_DEPTH = 4,    // power of 2, >= 2
    parameter int TIMEOUT    = 16    // 0 disables the wait-state timeout
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    busy,
    output logic [COMP-1:0]         PSELx,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [ADDR_WIDTH-1:0]   PADDR,
    output logic [DATA_WIDTH-1:0]   PWDATA,
    output logic [DATA_WIDTH/8-1:0] PSTRB,
    input  logic                    PREADY,
    input  logic [DATA_WIDTH-1:0]   PRDATA,
    input  logic                    PSLVERR,
    output logic [1:0]              dbg_state
);

    localparam int SW = DATA_WIDTH / 8;
    localparam int PW = $clog2(FIFO_DEPTH);
    // The select field is one bit wider than needed to name COMP completers,
    // so addresses just beyond the last completer decode as errors instead of
    // aliasing onto a real completer.
    localparam int IW = $clog2(COMP) + 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Command queue
    logic                  f_write_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] f_addr_q  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] f_wdata_q [FIFO_DEPTH];
    logic [SW-1:0]         f_strb_q  [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [PW:0]           count_q;
    logic                  full, empty, push, pop;

    // Latched command awaiting dispatch / being transferred
    logic                  stg_q;
    logic                  stg_write_q;
    logic [ADDR_WIDTH-1:0] stg_addr_q;
    logic [DATA_WIDTH-1:0] stg_wdata_q;
    logic [SW-1:0]         stg_strb_q;
    logic [IW-1:0]         stg_idx_q;
    logic                  stg_err_q;
    logic [IW-1:0]         head_idx;

    // APB drive registers hold their values between transfers
    logic                  pwrite_q;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic [SW-1:0]         pstrb_q;
    logic [COMP-1:0]       sel_onehot;

    logic [TW-1:0]         tmo_cnt_q;
    logic                  tmo_hit, done, dec_fire, dispatch;

    logic                  rsp_valid_q, rsp_err_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;

    assign full      = (count_q == (PW+1)'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && cmd_ready;
    // Only pop when the response slot will be free, so a finishing transfer
    // can never overwrite an unconsumed response.
    assign pop       = (state_q == S_IDLE) && !stg_q && !empty &&
                       (!rsp_valid_q || rsp_ready);
    assign head_idx  = f_addr_q[rd_ptr_q][SEL_LSB +: IW];

    assign dec_fire  = (state_q == S_IDLE) && stg_q && stg_err_q;
    assign dispatch  = (state_q == S_IDLE) && stg_q && !stg_err_q;
    assign tmo_hit   = (TIMEOUT != 0) && !PREADY && (tmo_cnt_q == TW'(TIMEOUT - 1));
    assign done      = (state_q == S_ACCESS) && (PREADY || tmo_hit);

    assign sel_onehot = {{(COMP-1){1'b0}}, 1'b1} << stg_idx_q;

    // FSM: state register
    always_ff @(posedge PCLK) begin
        if (PRESET) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (dispatch) state_d = S_SETUP;
            S_SETUP:  state_d = S_ACCESS;
            S_ACCESS: if (done) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        PSELx   = '0;
        PENABLE = 1'b0;
        case (state_q)
            S_SETUP:  PSELx = sel_onehot;
            S_ACCESS: begin
                PSELx   = sel_onehot;
                PENABLE = 1'b1;
            end
            default: ;
        endcase
    end

    // Queue storage needs no reset; only the pointers define its contents.
    always_ff @(posedge PCLK) begin
        if (push) begin
            f_write_q[wr_ptr_q] <= cmd_write;
            f_addr_q[wr_ptr_q]  <= cmd_addr;
            f_wdata_q[wr_ptr_q] <= cmd_wdata;
            f_strb_q[wr_ptr_q]  <= cmd_strb;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            stg_q       <= 1'b0;
            stg_write_q <= 1'b0;
            stg_addr_q  <= '0;
            stg_wdata_q <= '0;
            stg_strb_q  <= '0;
            stg_idx_q   <= '0;
            stg_err_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            tmo_cnt_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (push && !pop)      count_q <= count_q + (PW+1)'(1);
            else if (pop && !push) count_q <= count_q - (PW+1)'(1);

            if (pop) begin
                stg_q       <= 1'b1;
                stg_write_q <= f_write_q[rd_ptr_q];
                stg_addr_q  <= f_addr_q[rd_ptr_q];
                stg_wdata_q <= f_wdata_q[rd_ptr_q];
                stg_strb_q  <= f_strb_q[rd_ptr_q];
                stg_idx_q   <= head_idx;
                stg_err_q   <= (head_idx >= IW'(COMP));
            end else if (dec_fire || dispatch) begin
                stg_q <= 1'b0;
            end

            // Reads never expose write data or strobes on the bus.
            if (dispatch) begin
                pwrite_q <= stg_write_q;
                paddr_q  <= stg_addr_q;
                pwdata_q <= stg_write_q ? stg_wdata_q : '0;
                pstrb_q  <= stg_write_q ? stg_strb_q  : '0;
            end

            if (state_q == S_SETUP)
                tmo_cnt_q <= '0;
            else if (state_q == S_ACCESS && !PREADY && !tmo_hit)
                tmo_cnt_q <= tmo_cnt_q + TW'(1);

            if (dec_fire) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= 1'b1;
                rsp_rdata_q <= '0;
            end else if (done) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= PREADY ? PSLVERR : 1'b1;
                rsp_rdata_q <= (PREADY && !PSLVERR && !pwrite_q) ? PRDATA : '0;
            end else if (rsp_valid_q && rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PSTRB     = pstrb_q;
    // A latched command waiting for dispatch still counts as outstanding work.
    assign busy      = !empty || stg_q || (state_q != S_IDLE);
    assign dbg_state = state_q;

endmodule
